add_sub_sequencer: RTL and testbench
====================================

// Module: add_sub_sequencer
// PURPOSE
//  Upstream command stage for the 4-bit adder/subtractor datapath. Accepts LOAD/ADD/SUB/CLEAR
//  commands over valid/ready, drives the adder's i_A/i_B/i_Mode from registers, and captures
//  o_Sum/o_Cout into an accumulator. Returns each result with flags over valid/ready.
//  The adder is instantiated beside this block in the top wrapper.
// PARAMETERS
//  WIDTH   4  operand/accumulator width; must equal the adder width (4)
//  CNT_W   8  width of completed-operation counter o_op_count
// PORTS
//  i_clk        in   1      clock, all logic on rising edge
//  i_reset      in   1      synchronous, active-high reset
//  i_cmd_valid  in   1      command present
//  o_cmd_ready  out  1      command accepted when valid & ready at clock edge
//  i_cmd_op     in   2      LOAD=00 ADD=01 SUB=10 CLEAR=11
//  i_cmd_data   in   WIDTH  operand
//  o_A          out  WIDTH  to adder i_A (registered)
//  o_B          out  WIDTH  to adder i_B (registered)
//  o_Mode       out  1      to adder i_Mode; 1 = subtract (registered)
//  i_Sum        in   WIDTH  from adder o_Sum
//  i_Cout       in   1      from adder o_Cout; on SUB 1 = no borrow
//  o_res_valid  out  1      result present
//  i_res_ready  in   1      result consumed when valid & ready at edge
//  o_res_data   out  WIDTH  result, equals new accumulator
//  o_res_carry  out  1      captured i_Cout
//  o_res_zero   out  1      result == 0
//  o_res_ovf    out  1      signed two's-complement overflow
//  o_op_count   out  CNT_W  completed operations, wraps to 0
// BEHAVIOUR
//  - Reset: state S_IDLE, acc=0, o_A=0, o_B=0, o_Mode=0, o_res_valid=0, o_res_data=0,
//    all flags 0, o_op_count=0. o_cmd_ready=1 from the first cycle after reset.
//  - FSM: S_IDLE -> S_CALC on accept; S_CALC -> S_RESP unconditionally after 1 cycle;
//    S_RESP -> S_IDLE on i_res_ready.
//  - o_cmd_ready = (state==S_IDLE), combinational from state. No accept in S_CALC or S_RESP.
//  - On accept, register:
//    ADD: o_A=acc, o_B=data, o_Mode=0.   SUB: o_A=acc, o_B=data, o_Mode=1.
//    LOAD: o_A=0, o_B=data, o_Mode=0.    CLEAR: o_A=0, o_B=0, o_Mode=0.
//  - Hold o_A/o_B/o_Mode stable through S_CALC and until the next accept.
//  - End of S_CALC (capture edge):
//    acc and o_res_data <= i_Sum; o_res_carry <= i_Cout; o_res_zero <= (i_Sum==0).
//    o_res_ovf: ADD  -> A[W-1]==B[W-1] && Sum[W-1]!=A[W-1]
//               SUB  -> A[W-1]!=B[W-1] && Sum[W-1]!=A[W-1]
//               LOAD/CLEAR -> 0
//    o_op_count++ (mod 2^CNT_W); o_res_valid <= 1.
//  - Latency: accept at edge N, o_res_valid high from cycle N+2. Max throughput 1 op per 3 cycles.
//  - Backpressure: while o_res_valid & !i_res_ready, all o_res_* are held stable.
//    o_res_valid drops on the edge where i_res_ready=1; o_cmd_ready rises in the same cycle.
//  - Reset mid-op (S_CALC/S_RESP): in-flight op is discarded, no response issued, all state -> reset values.
//  - Arithmetic is modulo 2^WIDTH. Carry/borrow is exposed only through o_res_carry.
// STRUCTURE
//  - Package add_sub_pkg: op encodings OP_LOAD/OP_ADD/OP_SUB/OP_CLEAR, state enum
//    S_IDLE/S_CALC/S_RESP, WIDTH default.
//  - One sub-module: add_sub_flags (combinational; A, B, Mode, op, Sum -> zero, ovf).
//  - Top: FSM, operand registers, accumulator, result registers, counter.
// TESTING (bench drives a behavioural 4-bit add/sub model on o_A/o_B/o_Mode)
//  1. Reset, LOAD 10 -> o_A=0, o_B=10, o_Mode=0; res 10, carry 0, zero 0, ovf 0, count 1.
//  2. LOAD 10, SUB 9 -> o_A=10, o_B=9, o_Mode=1; res 1, carry 1, zero 0, ovf 0.
//  3. LOAD 10, ADD 8 -> res 2, carry 1, ovf 1 (-6 + -8); LOAD 3, SUB 5 -> res 14, carry 0, ovf 0.
//  4. LOAD 3, SUB 3 -> res 0, zero 1, carry 1; CLEAR -> res 0, zero 1, carry 0.
//  5. Hold i_res_ready=0 for 5 cycles with i_cmd_valid=1 -> outputs stable, o_cmd_ready=0,
//     no extra accept; release -> next command accepted, o_res_valid 2 cycles later.
//  6. Reset during S_CALC -> no o_res_valid, acc/count 0. With CNT_W=2, 5 ops -> o_op_count=1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub command sequencer.
// Contents:
//   DEF_WIDTH / DEF_CNT_W  default operand width and op-counter width
//   op_t                   command encodings carried on i_cmd_op
//   state_t                sequencer FSM states (also visible on o_state)
package add_sub_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/add_sub_flags.sv
// Result flag generation for the add/sub sequencer (purely combinational).
// Ports:
//   a, b   operands as presented to the adder
//   mode   1 = adder is subtracting
//   op     command that produced these operands (op_t encoding)
//   sum    adder sum output
//   zero   sum is all zeros
//   ovf    signed two's-complement overflow; always 0 for LOAD/CLEAR
module add_sub_flags
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] sum,
  output logic             zero,
  output logic             ovf
);

  // Subtraction is a + ~b + 1, so the sign the adder actually sees for
  // the second operand is inverted when mode is set. Overflow happens when
  // both effective operands share a sign and the sum's sign differs.
  logic b_sign_eff;

  always_comb begin
    b_sign_eff = mode ? ~b[WIDTH-1] : b[WIDTH-1];
    zero       = (sum == '0);
    ovf        = 1'b0;
    case (op_t'(op))
      OP_ADD, OP_SUB: ovf = (a[WIDTH-1] == b_sign_eff) && (sum[WIDTH-1] != a[WIDTH-1]);
      default:        ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/add_sub_sequencer.sv
// Command sequencer in front of a 4-bit adder/subtractor.
// Accepts LOAD/ADD/SUB/CLEAR commands, presents registered operands to the
// adder, captures its result into an accumulator and returns result+flags.
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and payload stable
// until that edge; ready may depend on state but never on valid.
//
// Ports:
//   i_clk, i_reset                clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready       command channel; i_cmd_op, i_cmd_data payload
//   o_A, o_B, o_Mode              registered adder inputs (o_Mode 1 = subtract)
//   i_Sum, i_Cout                 adder outputs
//   o_res_valid/i_res_ready       result channel
//   o_res_data/carry/zero/ovf     result payload
//   o_op_count                    completed operations, wraps
//   o_state                       current FSM state (debug visibility)
module add_sub_sequencer
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [WIDTH-1:0] o_A,
  output logic [WIDTH-1:0] o_B,
  output logic             o_Mode,
  input  logic [WIDTH-1:0] i_Sum,
  input  logic             i_Cout,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_carry,
  output logic             o_res_zero,
  output logic             o_res_ovf,
  output logic [CNT_W-1:0] o_op_count,
  output logic [1:0]       o_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic             cmd_accept;
  logic             flag_zero;
  logic             flag_ovf;

  assign o_cmd_ready = (state == S_IDLE);
  assign cmd_accept  = i_cmd_valid && o_cmd_ready;
  assign o_state     = state;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_accept) state_next = S_CALC;
      S_CALC:  state_next = S_RESP;
      S_RESP:  if (i_res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Flags are computed from the held operands and the live adder sum so
  // they can be captured on the same edge as the result.
  add_sub_flags #(.WIDTH(WIDTH)) u_flags (
    .a    (o_A),
    .b    (o_B),
    .mode (o_Mode),
    .op   (op_q),
    .sum  (i_Sum),
    .zero (flag_zero),
    .ovf  (flag_ovf)
  );

  // Operand registers: loaded only on accept, held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_A    <= '0;
      o_B    <= '0;
      o_Mode <= 1'b0;
      op_q   <= OP_LOAD;
    end else if (cmd_accept) begin
      op_q <= i_cmd_op;
      case (op_t'(i_cmd_op))
        OP_ADD: begin
          o_A    <= acc;
          o_B    <= i_cmd_data;
          o_Mode <= 1'b0;
        end
        OP_SUB: begin
          o_A    <= acc;
          o_B    <= i_cmd_data;
          o_Mode <= 1'b1;
        end
        OP_LOAD: begin
          o_A    <= '0;
          o_B    <= i_cmd_data;
          o_Mode <= 1'b0;
        end
        default: begin  // OP_CLEAR
          o_A    <= '0;
          o_B    <= '0;
          o_Mode <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator, result registers and op counter. The capture edge is the
  // one leaving S_CALC; result payload then stays frozen until the next
  // capture, which covers the backpressure hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc         <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_carry <= 1'b0;
      o_res_zero  <= 1'b0;
      o_res_ovf   <= 1'b0;
      o_op_count  <= '0;
    end else begin
      if (state == S_CALC) begin
        acc         <= i_Sum;
        o_res_data  <= i_Sum;
        o_res_carry <= i_Cout;
        o_res_zero  <= flag_zero;
        o_res_ovf   <= flag_ovf;
        o_op_count  <= o_op_count + CNT_ONE;
        o_res_valid <= 1'b1;
      end else if (state == S_RESP && i_res_ready) begin
        o_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Self-checking bench for add_sub_sequencer. Two instances share the
// stimulus: the default one (CNT_W=8) and one with CNT_W=2 to exercise
// counter wrap quickly. Each instance gets its own behavioural adder.
module tb_add_sub_sequencer;

  localparam int W = 4;
  localparam int OP_LOAD  = 0;
  localparam int OP_ADD   = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_CLEAR = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         res_ready;

  // instance 1 (CNT_W = 8)
  logic         cmd_ready, mode, res_valid, res_carry, res_zero, res_ovf, cout;
  logic [W-1:0] a, b, sum, res_data;
  logic [7:0]   op_count;
  logic [1:0]   state;

  // instance 2 (CNT_W = 2)
  logic         n_cmd_ready, n_mode, n_res_valid, n_res_carry, n_res_zero, n_res_ovf, n_cout;
  logic [W-1:0] n_a, n_b, n_sum, n_res_data;
  logic [1:0]   n_op_count;
  logic [1:0]   n_state;

  // Behavioural 4-bit adder/subtractor: subtract is a + ~b + 1.
  function automatic logic [W:0] adder(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    if (m) return {1'b0, x} + {1'b0, ~y} + 5'd1;
    else   return {1'b0, x} + {1'b0, y};
  endfunction

  assign {cout, sum}     = adder(a, b, mode);
  assign {n_cout, n_sum} = adder(n_a, n_b, n_mode);

  add_sub_sequencer #(.WIDTH(W), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
    .o_A(a), .o_B(b), .o_Mode(mode),
    .i_Sum(sum), .i_Cout(cout),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_carry(res_carry),
    .o_res_zero(res_zero), .o_res_ovf(res_ovf),
    .o_op_count(op_count), .o_state(state)
  );

  add_sub_sequencer #(.WIDTH(W), .CNT_W(2)) dut_small (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(n_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
    .o_A(n_a), .o_B(n_b), .o_Mode(n_mode),
    .i_Sum(n_sum), .i_Cout(n_cout),
    .o_res_valid(n_res_valid), .i_res_ready(res_ready),
    .o_res_data(n_res_data), .o_res_carry(n_res_carry),
    .o_res_zero(n_res_zero), .o_res_ovf(n_res_ovf),
    .o_op_count(n_op_count), .o_state(n_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int m_acc;
  int m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0;
    m_count = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"},  res_data, 0);
    check({tag, "_flags"},     {res_carry, res_zero, res_ovf}, 0);
    check({tag, "_count"},     op_count, 0);
    check({tag, "_a_b_mode"},  {a, b, mode}, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_state"},     state, 0);
    check({tag, "_small"},     {n_res_valid, n_op_count, n_state}, 0);
  endtask

  // Issue one command from idle, check operands, result and handshake.
  // 'hold' cycles of result backpressure are applied with a competing
  // command present to show that nothing else is accepted.
  task automatic do_op(input int op, input int data, input int hold);
    int ea, eb, em, res, carry, ovf, sr;
    logic [W-1:0] exp_r;
    cmd_op    = op[1:0];
    cmd_data  = data[W-1:0];
    cmd_valid = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1);
    case (op)
      OP_LOAD: begin
        ea = 0; eb = data; em = 0; res = data; carry = 0; ovf = 0;
      end
      OP_ADD: begin
        ea = m_acc; eb = data; em = 0;
        res   = (m_acc + data) % 16;
        carry = ((m_acc + data) >= 16) ? 1 : 0;
        sr    = sx(m_acc) + sx(data);
        ovf   = (sr > 7 || sr < -8) ? 1 : 0;
      end
      OP_SUB: begin
        ea = m_acc; eb = data; em = 1;
        res   = (m_acc - data + 16) % 16;
        carry = (m_acc >= data) ? 1 : 0;
        sr    = sx(m_acc) - sx(data);
        ovf   = (sr > 7 || sr < -8) ? 1 : 0;
      end
      default: begin
        ea = 0; eb = 0; em = 0; res = 0; carry = 0; ovf = 0;
      end
    endcase
    exp_q.push_back(res[W-1:0]);

    @(posedge clk); #1;  // accept edge
    cmd_valid = 1'b0;
    check("opnd_a", a, ea);
    check("opnd_b", b, eb);
    check("opnd_mode", mode, em);
    check("cmd_ready_calc", cmd_ready, 0);
    check("res_valid_calc", res_valid, 0);

    @(posedge clk); #1;  // capture edge
    m_acc = res;
    m_count++;
    exp_r = exp_q.pop_front();
    check("res_valid", res_valid, 1);
    check("res_data", res_data, exp_r);
    check("res_carry", res_carry, carry);
    check("res_zero", res_zero, (res == 0) ? 1 : 0);
    check("res_ovf", res_ovf, ovf);
    check("op_count", op_count, m_count % 256);
    check("op_count_small", n_op_count, m_count % 4);
    check("res_data_small", n_res_data, exp_r);

    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_payload", {res_data, res_carry, res_zero, res_ovf},
            {exp_r, carry[0], (res == 0), ovf[0]});
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_no_accept", {a, b, mode}, {ea[W-1:0], eb[W-1:0], em[0]});
    end

    res_ready = 1'b1;
    @(posedge clk); #1;  // release edge
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_cmd_ready", cmd_ready, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; res_ready = 1'b0;
    do_reset();
    check_reset_state("reset");

    // 1. LOAD 10
    do_op(OP_LOAD, 10, 0);
    // 2. LOAD 10, SUB 9
    do_op(OP_LOAD, 10, 0);
    do_op(OP_SUB, 9, 0);
    // 3. LOAD 10, ADD 8 (signed overflow); LOAD 3, SUB 5 (borrow)
    do_op(OP_LOAD, 10, 0);
    do_op(OP_ADD, 8, 0);
    do_op(OP_LOAD, 3, 0);
    do_op(OP_SUB, 5, 0);
    // 4. LOAD 3, SUB 3 -> zero; CLEAR
    do_op(OP_LOAD, 3, 0);
    do_op(OP_SUB, 3, 0);
    do_op(OP_CLEAR, 9, 0);
    // 5. backpressure for 5 cycles, then the next command goes straight in
    do_op(OP_LOAD, 7, 5);
    do_op(OP_ADD, 1, 0);

    // 6a. reset while in S_CALC
    do_reset();
    cmd_op = 2'(OP_ADD); cmd_data = 4'd5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("rst_calc");
    @(posedge clk); #1;
    check("rst_calc_no_resp", res_valid, 0);
    m_acc = 0; m_count = 0; exp_q.delete();

    // 6b. reset while a result is waiting in S_RESP
    do_op(OP_LOAD, 6, 0);
    cmd_op = 2'(OP_ADD); cmd_data = 4'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("rst_resp");
    m_acc = 0; m_count = 0; exp_q.delete();
    do_op(OP_ADD, 5, 0);  // accumulator must start from 0 again

    // 6c. CNT_W=2 wrap after 5 ops (4 more here), plus random traffic
    //     long enough to wrap the 8-bit counter.
    for (int i = 0; i < 4; i++) do_op(OP_LOAD, i, 0);
    check("small_wrap_5ops", n_op_count, 1);
    for (int i = 0; i < 260; i++)
      do_op($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
